// File: rtl/regfile_pkg.sv
// Shared defaults for the register file / busy scoreboard slice.
package regfile_pkg;
  localparam int DEFAULT_DATA_WIDTH  = 32;
  localparam int DEFAULT_ADDR_WIDTH  = 5;
  localparam int DEFAULT_DEBUG_REG_A = 1;
  localparam int DEFAULT_DEBUG_REG_B = 13;
  localparam int ZERO_REG            = 0;
endpackage

// File: rtl/regfile_if.sv
// Register-file port bundle: write port, two read ports, scoreboard control and debug taps.
interface regfile_if #(
  parameter int DATA_WIDTH = regfile_pkg::DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::DEFAULT_ADDR_WIDTH
);
  logic                  ctrl_writeEnable;
  logic [ADDR_WIDTH-1:0] ctrl_writeReg;
  logic [DATA_WIDTH-1:0] data_writeReg;
  logic [ADDR_WIDTH-1:0] ctrl_readRegA;
  logic [ADDR_WIDTH-1:0] ctrl_readRegB;
  logic [DATA_WIDTH-1:0] data_readRegA;
  logic [DATA_WIDTH-1:0] data_readRegB;
  logic                  ctrl_issueEnable;
  logic [ADDR_WIDTH-1:0] ctrl_issueReg;
  logic                  ctrl_flush;
  logic                  busy_readRegA;
  logic                  busy_readRegB;
  logic [ADDR_WIDTH:0]   busy_count;
  logic [DATA_WIDTH-1:0] data_debugA;
  logic [DATA_WIDTH-1:0] data_debugB;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output ctrl_readRegA, ctrl_readRegB,
    output ctrl_issueEnable, ctrl_issueReg, ctrl_flush,
    input  data_readRegA, data_readRegB, busy_readRegA, busy_readRegB,
    input  busy_count, data_debugA, data_debugB
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  ctrl_readRegA, ctrl_readRegB,
    input  ctrl_issueEnable, ctrl_issueReg, ctrl_flush,
    output data_readRegA, data_readRegB, busy_readRegA, busy_readRegB,
    output busy_count, data_debugA, data_debugB
  );
endinterface

// File: rtl/regfile_busy_tracker.sv
// Per-register busy scoreboard with issue/writeback/flush priority and a running busy count.
module regfile_busy_tracker
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_reg,
  input  logic                  issue_en,
  input  logic [ADDR_WIDTH-1:0] issue_reg,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] rd_reg_a,
  input  logic [ADDR_WIDTH-1:0] rd_reg_b,
  output logic                  busy_a,
  output logic                  busy_b,
  output logic [ADDR_WIDTH:0]   busy_count
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [NUM_REGS-1:0] busy;
  logic                set_v;
  logic                clr_v;
  logic                set_new;
  logic                cleared;

  assign set_v = issue_en && (issue_reg != ADDR_WIDTH'(ZERO_REG)) && !flush;
  assign clr_v = wr_en && (wr_reg != ADDR_WIDTH'(ZERO_REG));

  // A clear on the index being re-issued is superseded by the set, so it never counts down.
  assign set_new = set_v && !busy[issue_reg];
  assign cleared = clr_v && busy[wr_reg] && !(set_v && (issue_reg == wr_reg));

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      busy       <= '0;
      busy_count <= '0;
    end else if (flush) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (clr_v) busy[wr_reg]    <= 1'b0;
      if (set_v) busy[issue_reg] <= 1'b1;
      busy_count <= busy_count + (ADDR_WIDTH+1)'(set_new) - (ADDR_WIDTH+1)'(cleared);
    end
  end

  assign busy_a = busy[rd_reg_a] && !(clr_v && (wr_reg == rd_reg_a));
  assign busy_b = busy[rd_reg_b] && !(clr_v && (wr_reg == rd_reg_b));
endmodule

// File: rtl/regfile_scoreboard.sv
// Register file (r0 hardwired to zero) with write-to-read bypass, busy scoreboard and debug taps.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int DEBUG_REG_A = DEFAULT_DEBUG_REG_A,
  parameter int DEBUG_REG_B = DEFAULT_DEBUG_REG_B
) (
  input  logic      clock,
  input  logic      ctrl_reset,
  regfile_if.slave  bus
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];
  logic                  wr_valid;

  assign wr_valid = bus.ctrl_writeEnable && (bus.ctrl_writeReg != ADDR_WIDTH'(ZERO_REG));

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_valid) begin
      regs[bus.ctrl_writeReg] <= bus.data_writeReg;
    end
  end

  // Read ports: r0 reads zero, a same-cycle write to the read index is forwarded.
  always_comb begin
    bus.data_readRegA = '0;
    bus.data_readRegB = '0;
    if (bus.ctrl_readRegA != ADDR_WIDTH'(ZERO_REG)) begin
      if (wr_valid && (bus.ctrl_writeReg == bus.ctrl_readRegA))
        bus.data_readRegA = bus.data_writeReg;
      else
        bus.data_readRegA = regs[bus.ctrl_readRegA];
    end
    if (bus.ctrl_readRegB != ADDR_WIDTH'(ZERO_REG)) begin
      if (wr_valid && (bus.ctrl_writeReg == bus.ctrl_readRegB))
        bus.data_readRegB = bus.data_writeReg;
      else
        bus.data_readRegB = regs[bus.ctrl_readRegB];
    end
  end

  generate
    if (DEBUG_REG_A == ZERO_REG) begin : g_dbg_a_zero
      assign bus.data_debugA = '0;
    end else begin : g_dbg_a
      assign bus.data_debugA = regs[DEBUG_REG_A];
    end
    if (DEBUG_REG_B == ZERO_REG) begin : g_dbg_b_zero
      assign bus.data_debugB = '0;
    end else begin : g_dbg_b
      assign bus.data_debugB = regs[DEBUG_REG_B];
    end
  endgenerate

  regfile_busy_tracker #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_busy (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .wr_en      (bus.ctrl_writeEnable),
    .wr_reg     (bus.ctrl_writeReg),
    .issue_en   (bus.ctrl_issueEnable),
    .issue_reg  (bus.ctrl_issueReg),
    .flush      (bus.ctrl_flush),
    .rd_reg_a   (bus.ctrl_readRegA),
    .rd_reg_b   (bus.ctrl_readRegB),
    .busy_a     (bus.busy_readRegA),
    .busy_b     (bus.busy_readRegB),
    .busy_count (bus.busy_count)
  );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: bypass, r0, busy set/clear/flush, async reset.
module tb_regfile_scoreboard;
  logic clock;
  logic ctrl_reset;
  int   n_tests;
  int   n_fail;

  regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  regfile_scoreboard #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (5),
    .DEBUG_REG_A (1),
    .DEBUG_REG_B (13)
  ) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle();
    bus.ctrl_writeEnable = 1'b0;
    bus.ctrl_writeReg    = '0;
    bus.data_writeReg    = '0;
    bus.ctrl_issueEnable = 1'b0;
    bus.ctrl_issueReg    = '0;
    bus.ctrl_flush       = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    bus.ctrl_readRegA = 5'd5;
    bus.ctrl_readRegB = 5'd13;
    ctrl_reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_tests++;
    if (bus.busy_count !== 6'd0) begin
      n_fail++; $display("FAIL reset_busy_count got %0d expected 0", bus.busy_count);
    end
    n_tests++;
    if (bus.data_debugA !== 32'h0 || bus.data_debugB !== 32'h0) begin
      n_fail++; $display("FAIL reset_debug got %h/%h expected 0/0", bus.data_debugA, bus.data_debugB);
    end
    n_tests++;
    if (bus.data_readRegA !== 32'h0 || bus.busy_readRegA !== 1'b0) begin
      n_fail++; $display("FAIL reset_read got %h busy %b expected 0 busy 0", bus.data_readRegA, bus.busy_readRegA);
    end
    @(negedge clock);
    ctrl_reset = 1'b1;
  endtask

  task automatic test_bypass();
    @(negedge clock);
    bus.ctrl_writeEnable = 1'b1;
    bus.ctrl_writeReg    = 5'd5;
    bus.data_writeReg    = 32'hDEADBEEF;
    bus.ctrl_readRegA    = 5'd5;
    #1;
    n_tests++;
    if (bus.data_readRegA !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bypass_same_cycle got %h expected deadbeef", bus.data_readRegA);
    end
    @(negedge clock);
    idle();
    #1;
    n_tests++;
    if (bus.data_readRegA !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bypass_stored got %h expected deadbeef", bus.data_readRegA);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clock);
    bus.ctrl_writeEnable = 1'b1;
    bus.ctrl_writeReg    = 5'd0;
    bus.data_writeReg    = 32'h1234;
    bus.ctrl_issueEnable = 1'b1;
    bus.ctrl_issueReg    = 5'd0;
    bus.ctrl_readRegA    = 5'd0;
    bus.ctrl_readRegB    = 5'd0;
    #1;
    n_tests++;
    if (bus.data_readRegA !== 32'h0 || bus.data_readRegB !== 32'h0) begin
      n_fail++; $display("FAIL zero_read_bypass got %h/%h expected 0/0", bus.data_readRegA, bus.data_readRegB);
    end
    @(negedge clock);
    idle();
    #1;
    n_tests++;
    if (bus.data_readRegA !== 32'h0 || bus.busy_readRegA !== 1'b0 || bus.busy_readRegB !== 1'b0) begin
      n_fail++; $display("FAIL zero_after got %h busy %b%b expected 0 busy 00",
                         bus.data_readRegA, bus.busy_readRegA, bus.busy_readRegB);
    end
    n_tests++;
    if (bus.busy_count !== 6'd0) begin
      n_fail++; $display("FAIL zero_busy_count got %0d expected 0", bus.busy_count);
    end
  endtask

  task automatic test_issue();
    logic [4:0] seq [3];
    logic [5:0] exp_cnt [3];
    seq[0] = 5'd3; seq[1] = 5'd7; seq[2] = 5'd3;
    exp_cnt[0] = 6'd1; exp_cnt[1] = 6'd2; exp_cnt[2] = 6'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      bus.ctrl_issueEnable = 1'b1;
      bus.ctrl_issueReg    = seq[i];
      @(posedge clock);
      #1;
      n_tests++;
      if (bus.busy_count !== exp_cnt[i]) begin
        n_fail++; $display("FAIL issue_count_%0d got %0d expected %0d", i, bus.busy_count, exp_cnt[i]);
      end
    end
    @(negedge clock);
    idle();
    bus.ctrl_writeEnable = 1'b1;
    bus.ctrl_writeReg    = 5'd3;
    bus.data_writeReg    = 32'h33;
    bus.ctrl_readRegA    = 5'd3;
    bus.ctrl_readRegB    = 5'd7;
    #1;
    n_tests++;
    if (bus.busy_readRegA !== 1'b0 || bus.busy_readRegB !== 1'b1) begin
      n_fail++; $display("FAIL writeback_mask got %b%b expected 01", bus.busy_readRegA, bus.busy_readRegB);
    end
    @(posedge clock);
    #1;
    n_tests++;
    if (bus.busy_count !== 6'd1) begin
      n_fail++; $display("FAIL writeback_count got %0d expected 1", bus.busy_count);
    end
    @(negedge clock);
    idle();
    #1;
    n_tests++;
    if (bus.busy_readRegA !== 1'b0 || bus.busy_readRegB !== 1'b1) begin
      n_fail++; $display("FAIL writeback_stored got %b%b expected 01", bus.busy_readRegA, bus.busy_readRegB);
    end
  endtask

  task automatic test_issue_write_same();
    @(negedge clock);
    bus.ctrl_issueEnable = 1'b1;
    bus.ctrl_issueReg    = 5'd9;
    bus.ctrl_writeEnable = 1'b1;
    bus.ctrl_writeReg    = 5'd9;
    bus.data_writeReg    = 32'h99;
    bus.ctrl_readRegA    = 5'd9;
    #1;
    n_tests++;
    if (bus.busy_readRegA !== 1'b0) begin
      n_fail++; $display("FAIL same_issue_visible got %b expected 0", bus.busy_readRegA);
    end
    @(negedge clock);
    idle();
    #1;
    n_tests++;
    if (bus.busy_readRegA !== 1'b1 || bus.busy_count !== 6'd2) begin
      n_fail++; $display("FAIL same_set_wins got busy %b count %0d expected busy 1 count 2",
                         bus.busy_readRegA, bus.busy_count);
    end
    n_tests++;
    if (bus.data_readRegA !== 32'h99) begin
      n_fail++; $display("FAIL same_data got %h expected 99", bus.data_readRegA);
    end
  endtask

  task automatic test_flush();
    @(negedge clock);
    bus.ctrl_issueEnable = 1'b1;
    bus.ctrl_issueReg    = 5'd2;
    @(posedge clock);
    #1;
    n_tests++;
    if (bus.busy_count !== 6'd3) begin
      n_fail++; $display("FAIL flush_pre_count got %0d expected 3", bus.busy_count);
    end
    @(negedge clock);
    bus.ctrl_flush       = 1'b1;
    bus.ctrl_issueEnable = 1'b1;
    bus.ctrl_issueReg    = 5'd4;
    bus.ctrl_writeEnable = 1'b1;
    bus.ctrl_writeReg    = 5'd4;
    bus.data_writeReg    = 32'h55;
    @(negedge clock);
    idle();
    bus.ctrl_readRegA = 5'd4;
    bus.ctrl_readRegB = 5'd7;
    #1;
    n_tests++;
    if (bus.busy_count !== 6'd0) begin
      n_fail++; $display("FAIL flush_count got %0d expected 0", bus.busy_count);
    end
    n_tests++;
    if (bus.busy_readRegA !== 1'b0 || bus.busy_readRegB !== 1'b0) begin
      n_fail++; $display("FAIL flush_busy got %b%b expected 00", bus.busy_readRegA, bus.busy_readRegB);
    end
    n_tests++;
    if (bus.data_readRegA !== 32'h55) begin
      n_fail++; $display("FAIL flush_data got %h expected 55", bus.data_readRegA);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    bus.ctrl_writeEnable = 1'b1;
    bus.ctrl_writeReg    = 5'd1;
    bus.data_writeReg    = 32'hA;
    @(negedge clock);
    bus.ctrl_writeReg    = 5'd13;
    bus.data_writeReg    = 32'hB;
    bus.ctrl_issueEnable = 1'b1;
    bus.ctrl_issueReg    = 5'd6;
    @(negedge clock);
    idle();
    #1;
    n_tests++;
    if (bus.data_debugA !== 32'hA || bus.data_debugB !== 32'hB) begin
      n_fail++; $display("FAIL debug_taps got %h/%h expected a/b", bus.data_debugA, bus.data_debugB);
    end
    n_tests++;
    if (bus.busy_count !== 6'd1) begin
      n_fail++; $display("FAIL premid_count got %0d expected 1", bus.busy_count);
    end
    @(negedge clock);
    bus.ctrl_writeEnable = 1'b1;
    bus.ctrl_writeReg    = 5'd1;
    bus.data_writeReg    = 32'hFFFF;
    #2;
    ctrl_reset = 1'b0;
    #1;
    n_tests++;
    if (bus.data_debugA !== 32'h0 || bus.data_debugB !== 32'h0 || bus.busy_count !== 6'd0) begin
      n_fail++; $display("FAIL reset_async got %h/%h count %0d expected 0/0 count 0",
                         bus.data_debugA, bus.data_debugB, bus.busy_count);
    end
    @(posedge clock);
    #1;
    n_tests++;
    if (bus.data_debugA !== 32'h0) begin
      n_fail++; $display("FAIL reset_hold got %h expected 0", bus.data_debugA);
    end
    @(negedge clock);
    idle();
    ctrl_reset = 1'b1;
    bus.ctrl_readRegA = 5'd1;
    bus.ctrl_readRegB = 5'd13;
    #1;
    n_tests++;
    if (bus.data_readRegA !== 32'h0 || bus.data_readRegB !== 32'h0) begin
      n_fail++; $display("FAIL reset_no_write got %h/%h expected 0/0", bus.data_readRegA, bus.data_readRegB);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    ctrl_reset = 1'b1;
    bus.ctrl_readRegA = '0;
    bus.ctrl_readRegB = '0;
    idle();
    test_reset();
    test_bypass();
    test_zero_reg();
    test_issue();
    test_issue_write_same();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised general-purpose register file for the processor core: one write port, two read ports, and a per-register busy scoreboard that tracks registers awaiting a pending writeback. Same-cycle writes are forwarded to the read ports. Register 0 is hardwired to zero. Two compile-time-selected registers are exported as debug taps for the display/game logic.

## Interface
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH
- DEBUG_REG_A, 1, index exported on data_debugA
- DEBUG_REG_B, 13, index exported on data_debugB
- clock  in  1  sole clock, rising edge
- ctrl_reset  in  1  asynchronous, active-low reset
- ctrl_writeEnable  in  1  write strobe
- ctrl_writeReg  in  ADDR_WIDTH  write index
- data_writeReg  in  DATA_WIDTH  write data
- ctrl_readRegA, ctrl_readRegB  in  ADDR_WIDTH  read indices
- data_readRegA, data_readRegB  out  DATA_WIDTH  read data, combinational
- ctrl_issueEnable  in  1  mark ctrl_issueReg busy (producer issued)
- ctrl_issueReg  in  ADDR_WIDTH  index to mark busy
- ctrl_flush  in  1  synchronous clear of all busy bits
- busy_readRegA, busy_readRegB  out  1  busy status of read indices
- busy_count  out  ADDR_WIDTH+1  number of busy registers, registered
- data_debugA, data_debugB  out  DATA_WIDTH  contents of DEBUG_REG_A/B, registered state

## Operation
- Storage: NUM_REGS-1 registers of DATA_WIDTH (index 0 not stored); write on rising edge when ctrl_writeEnable=1 and ctrl_writeReg≠0.
- Index 0: reads 0, never busy; writes and issues to 0 ignored.
- Read bypass: if ctrl_writeEnable=1, ctrl_writeReg=ctrl_readRegX≠0, data_readRegX=data_writeReg; else stored value.
- Busy set: ctrl_issueEnable=1, ctrl_issueReg≠0, ctrl_flush=0 → busy[ctrl_issueReg]=1 next cycle.
- Busy clear: valid write (ctrl_writeEnable=1, ctrl_writeReg≠0) → busy[ctrl_writeReg]=0 next cycle.
- Same index issued and written in one cycle: set wins (new producer supersedes completed one).
- ctrl_flush=1: all busy bits 0 next cycle, concurrent issue ignored; concurrent write still updates data.
- busy_readRegX = busy[ctrl_readRegX] & ~(valid write to ctrl_readRegX this cycle); same-cycle issue not visible until next cycle.
- busy_count: counter, next = count + set_new − cleared, where set_new=1 only if bit was 0, cleared=1 only if bit was 1; flush → 0. Must always equal popcount(busy).
- Debug taps: data_debugA/B show stored value (no bypass); DEBUG_REG_x=0 → constant 0.

## Timing
- Reset (ctrl_reset=0, asynchronous): all registers 0, all busy 0, busy_count 0, data_debugA/B 0; data_readRegX 0 unless bypassing a write. Release is synchronous to clock externally; block assumes clean deassertion.
- Write latency: 0 cycles via bypass, 1 cycle to storage/debug taps.
- Busy set/clear/flush: effective on the next rising edge; busy_count updates on the same edge.
- Reset mid-operation: overrides write, issue and flush immediately.
- No handshake stalls; every input sampled every cycle.

## Structure
- Package regfile_pkg: default DATA_WIDTH/ADDR_WIDTH, DEBUG_REG defaults, zero-register index constant.
- Sub-module regfile_busy_tracker: busy bit vector, set/clear/flush priority, busy_count counter, busy read masking. Data array and bypass muxes in top level.

## Test plan
- Reset, write 0xDEADBEEF to r5, read A=5 same cycle → data_readRegA=0xDEADBEEF via bypass; next cycle (no write) still 0xDEADBEEF.
- Write 0x1234 to r0, read A=B=0 → both 0, busy 0, busy_count 0.
- Issue r3, r7, r3 on consecutive cycles → busy_count 1,2,2; write r3 → busy_readRegA(3)=0 same cycle, busy_count 1 next.
- Issue r9 and write r9 same cycle → busy[9]=1 after edge, busy_count +1, data stored.
- Three busy registers, flush with concurrent issue r4 and write r4=0x55 → busy_count 0, r4 not busy, r4 reads 0x55.
- Write r1=0xA, r13=0xB, then assert ctrl_reset mid-write to r1 → data_debugA/B go 0 immediately, no write lands.
